// File: rtl/bldc_pkg.sv
// Shared hall-code definitions for the BLDC hall generator and its helpers.
package bldc_pkg;

  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  // Forward 120-degree hall sequence, indexed 0..5
  localparam logic [2:0] HALL_IDX0 = 3'b001;
  localparam logic [2:0] HALL_IDX1 = 3'b101;
  localparam logic [2:0] HALL_IDX2 = 3'b100;
  localparam logic [2:0] HALL_IDX3 = 3'b110;
  localparam logic [2:0] HALL_IDX4 = 3'b010;
  localparam logic [2:0] HALL_IDX5 = 3'b011;

  typedef enum logic {ST_IDLE, ST_RUN} gen_state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } hall_idx_t;

  function automatic logic [2:0] hall_idx2code(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = HALL_IDX0;
      3'd1:    c = HALL_IDX1;
      3'd2:    c = HALL_IDX2;
      3'd3:    c = HALL_IDX3;
      3'd4:    c = HALL_IDX4;
      3'd5:    c = HALL_IDX5;
      default: c = HALL_IDX0;
    endcase
    return c;
  endfunction

  function automatic hall_idx_t hall_code2idx(input logic [2:0] code);
    hall_idx_t r;
    r.vld = 1'b1;
    case (code)
      HALL_IDX0: r.idx = 3'd0;
      HALL_IDX1: r.idx = 3'd1;
      HALL_IDX2: r.idx = 3'd2;
      HALL_IDX3: r.idx = 3'd3;
      HALL_IDX4: r.idx = 3'd4;
      HALL_IDX5: r.idx = 3'd5;
      default: begin
        r.vld = 1'b0;
        r.idx = 3'd0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bldc_step_timer.sv
// Step period counter: counts while running, ticks when the count reaches period-1.
module bldc_step_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // >= lets a shrinking period fire at once; count never passes period-1 so no wrap
  assign tick_o = run_i && (cnt_q >= (period_i - ONE));

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clear_i || !run_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bldc_hall_gen.sv
// Hall sensor pattern generator: steps a 6-state hall code at a programmable period.
module bldc_hall_gen
  import bldc_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [2:0] RST_CODE = 3'b001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             load_i,
  input  logic [2:0]       start_code_i,
  output logic [2:0]       hall_o,
  output logic             step_o,
  output logic             rev_o,
  output logic [2:0]       pos_o,
  output logic             load_err_o
);

  localparam hall_idx_t RST_LU = hall_code2idx(RST_CODE);

  gen_state_e state_q, state_d;
  logic [2:0] pos_q, pos_d, hall_q, nxt_idx;
  logic       step_q, step_d, rev_q, rev_d, lerr_q, lerr_d;
  logic       go, run, tick, adv, load_ok, wrap;
  hall_idx_t  ld;

  assign go  = en_i && (period_i != '0);
  // Drop out of counting the same cycle enable/period go away
  assign run = (state_q == ST_RUN) && go;

  bldc_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (run),
    .clear_i  (load_ok),
    .period_i (period_i),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = go ? ST_RUN : ST_IDLE;
    ld      = hall_code2idx(start_code_i);
    load_ok = load_i && ld.vld;
    adv     = tick && !load_ok;
    if (dir_i == FWD) begin
      nxt_idx = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
      wrap    = (pos_q == 3'd5);
    end else begin
      nxt_idx = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
      wrap    = (pos_q == 3'd0);
    end
    pos_d = pos_q;
    if (load_ok)  pos_d = ld.idx;
    else if (adv) pos_d = nxt_idx;
    step_d = adv;
    rev_d  = adv && wrap;
    lerr_d = load_i && !ld.vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= RST_LU.idx;
      hall_q  <= RST_CODE;
      step_q  <= 1'b0;
      rev_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hall_q  <= hall_idx2code(pos_d);
      step_q  <= step_d;
      rev_q   <= rev_d;
      lerr_q  <= lerr_d;
    end
  end

  assign hall_o     = hall_q;
  assign pos_o      = pos_q;
  assign step_o     = step_q;
  assign rev_o      = rev_q;
  assign load_err_o = lerr_q;

endmodule

// File: tb/tb_bldc_hall_gen.sv
// Directed scoreboard bench for bldc_hall_gen.
module tb_bldc_hall_gen;

  typedef struct packed {
    logic [2:0] hall;
    logic [2:0] pos;
    logic       step;
    logic       rev;
    logic       lerr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, dir_i, load_i;
  logic [15:0] period_i;
  logic [2:0]  start_code_i;
  logic [2:0]  hall_o, pos_o;
  logic        step_o, rev_o, load_err_o;

  int checks = 0;
  int errors = 0;
  int cur    = 0;
  obs_t sb[$];
  logic [2:0] tbl [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

  always #5 clk = ~clk;

  bldc_hall_gen #(.CNT_W(16), .RST_CODE(3'b001)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .dir_i        (dir_i),
    .period_i     (period_i),
    .load_i       (load_i),
    .start_code_i (start_code_i),
    .hall_o       (hall_o),
    .step_o       (step_o),
    .rev_o        (rev_o),
    .pos_o        (pos_o),
    .load_err_o   (load_err_o)
  );

  task automatic chk(input string tag, input obs_t exp);
    obs_t got;
    got = '{hall_o, pos_o, step_o, rev_o, load_err_o};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got hall=%b pos=%0d step=%b rev=%b lerr=%b exp hall=%b pos=%0d step=%b rev=%b lerr=%b",
             tag, got.hall, got.pos, got.step, got.rev, got.lerr,
             exp.hall, exp.pos, exp.step, exp.rev, exp.lerr);
    end
  endtask

  // One clock: queue the expected post-edge outputs, then pop and compare
  task automatic cyc(input string tag, input int idx, input logic s, input logic r, input logic e);
    obs_t exp;
    exp = '{tbl[idx], 3'(idx), s, r, e};
    sb.push_back(exp);
    @(posedge clk); #1;
    exp = sb.pop_front();
    chk(tag, exp);
  endtask

  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, cur, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adv_to(input string tag, input int idx, input logic r);
    cur = idx;
    cyc(tag, cur, 1'b1, r, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en_i = 1'b0; dir_i = 1'b0; load_i = 1'b0;
    period_i = 16'd4; start_code_i = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", '{3'b001, 3'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Forward, period 4: one entry cycle plus 3 counting cycles before each advance
    en_i = 1'b1;
    hold("fwd_entry", 4);
    adv_to("fwd", 1, 1'b0);
    hold("fwd", 3); adv_to("fwd", 2, 1'b0);
    hold("fwd", 3); adv_to("fwd", 3, 1'b0);
    hold("fwd", 3); adv_to("fwd", 4, 1'b0);
    hold("fwd", 3); adv_to("fwd", 5, 1'b0);
    hold("fwd", 3); adv_to("fwd_wrap", 0, 1'b1);

    // Reverse from 001
    dir_i = 1'b1;
    hold("rev", 3); adv_to("rev_wrap", 5, 1'b1);
    hold("rev", 3); adv_to("rev", 4, 1'b0);
    hold("rev", 3); adv_to("rev", 3, 1'b0);
    hold("rev", 3); adv_to("rev", 2, 1'b0);
    hold("rev", 3); adv_to("rev", 1, 1'b0);
    hold("rev", 3); adv_to("rev", 0, 1'b0);

    // Valid load at terminal count beats the advance
    dir_i = 1'b0;
    hold("pre_load", 3);
    load_i = 1'b1; start_code_i = 3'b110;
    cur = 3;
    cyc("load_ok", cur, 1'b0, 1'b0, 1'b0);
    load_i = 1'b0;
    hold("post_load", 3); adv_to("post_load", 4, 1'b0);

    // Invalid load at terminal count: error pulse, advance still happens
    hold("pre_bad", 3);
    load_i = 1'b1; start_code_i = 3'b111;
    cur = 5;
    cyc("load_bad", cur, 1'b1, 1'b0, 1'b1);
    load_i = 1'b0;

    // Shrink period 10 -> 2 with count at 5
    period_i = 16'd10;
    hold("p10", 5);
    period_i = 16'd2;
    adv_to("shrink", 0, 1'b1);
    hold("p2", 1); adv_to("p2", 1, 1'b0);

    // Period 0 freezes
    period_i = 16'd0;
    hold("p0_hold", 6);

    // Enable drop mid-period restarts the count
    period_i = 16'd4;
    hold("reen", 3);
    en_i = 1'b0;
    hold("en_low", 2);
    en_i = 1'b1;
    hold("en_restart", 4); adv_to("en_restart", 2, 1'b0);

    // Period 1 steps every cycle
    period_i = 16'd1;
    adv_to("p1", 3, 1'b0);
    adv_to("p1", 4, 1'b0);
    adv_to("p1", 5, 1'b0);
    adv_to("p1_wrap", 0, 1'b1);
    period_i = 16'd4;
    hold("p4", 3); adv_to("p4", 1, 1'b0);

    // Async reset while step_o is high
    rst_n = 1'b0;
    #1;
    chk("async_rst", '{3'b001, 3'd0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 0;
    hold("after_rst", 4); adv_to("after_rst", 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
